// File: rtl/dmem_responder.sv
// dmem_responder: answers one outstanding datapath load/store by driving the RAM port; dhit two or more cycles after the request.
// The requester holds its enable until dhit; a stuck RAM is abandoned after TIMEOUT REQ cycles with derror.
// Defining DMEM_RESP_READBUF_EN adds a one-entry load buffer that answers repeated loads in one cycle.
module dmem_responder #(
    parameter int TIMEOUT = 255,
    parameter int WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              derror,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [7:0]        CNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [WORD_W-1:0] WORD_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

    logic [1:0]        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] load_q, load_d;
    logic [WORD_W-1:0] req_addr;

`ifdef DMEM_RESP_READBUF_EN
    logic              buf_vld_q, buf_vld_d;
    logic [WORD_W-1:0] buf_addr_q, buf_addr_d;
    logic [WORD_W-1:0] buf_dat_q, buf_dat_d;
`endif

    assign req_addr = dmemaddr & WORD_MASK;

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
`ifdef DMEM_RESP_READBUF_EN
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_dat_d  = buf_dat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dmemWEN || dmemREN) begin
                    op_wr_d = dmemWEN;
                    addr_d  = req_addr;
                    store_d = dmemstore;
                    cnt_d   = '0;
                    state_d = ST_REQ;
`ifdef DMEM_RESP_READBUF_EN
                    if (!dmemWEN && buf_vld_q && (buf_addr_q == req_addr)) begin
                        load_d  = buf_dat_q;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_REQ: begin
                if (ramstate == RAM_ACCESS) begin
                    state_d = ST_DONE;
                    if (!op_wr_q) begin
                        load_d = ramload;
                    end
`ifdef DMEM_RESP_READBUF_EN
                    if (!op_wr_q) begin
                        buf_vld_d  = 1'b1;
                        buf_addr_d = addr_q;
                        buf_dat_d  = ramload;
                    end else if (buf_vld_q && (buf_addr_q == addr_q)) begin
                        buf_dat_d = store_q;
                    end
`endif
                end else if ((ramstate == RAM_ERROR) || (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
`ifdef DMEM_RESP_READBUF_EN
                    buf_vld_d = 1'b0;
`endif
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

`ifdef DMEM_RESP_READBUF_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_dat_q  <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_dat_q  <= buf_dat_d;
        end
    end
`endif

    assign dhit     = (state_q == ST_DONE);
    assign derror   = (state_q == ST_DONE) && err_q;
    assign ramREN   = (state_q == ST_REQ) && !op_wr_q;
    assign ramWEN   = (state_q == ST_REQ) && op_wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign dmemload = load_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: the driver predicts each response from a transaction-level
// model and queues it; the monitor matches every dhit against the queue head.
module tb_dmem_responder;
    localparam int TO = 4;
`ifdef DMEM_RESP_READBUF_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int T_ACC  = 0;
    localparam int T_ERR  = 1;
    localparam int T_NONE = 2;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, derror, ramREN, ramWEN;
    logic [31:0] dmemload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = RS_FREE;

    dmem_responder #(.TIMEOUT(TO), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .derror(derror),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          exp_cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    // transaction-level memory-side model state
    logic [31:0] m_load = '0;
    bit          m_bv = 1'b0;
    logic [31:0] m_ba = '0;
    logic [31:0] m_bd = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    exp_t mon_e;
    always @(negedge CLK) begin
        if (dhit === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_dhit", 96'(dhit), 96'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("dhit_cycle", 96'(cyc), 96'(mon_e.exp_cyc));
                chk("derror", 96'(derror), 96'(mon_e.err));
                chk("dmemload", 96'(dmemload), 96'(mon_e.data));
            end
        end else begin
            if (derror === 1'b1) chk("derror_without_dhit", 96'(derror), 96'd0);
            if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                chk("dhit_missing", 96'(dhit), 96'd1);
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] sdat,
                       input int w, input int term, input logic [31:0] rdat);
        logic        wr;
        logic [31:0] wa;
        bit          hit;
        int          nreq;
        exp_t        e;
        wr  = wen;
        wa  = {addr[31:2], 2'b00};
        hit = RB && !wr && m_bv && (m_ba == wa);
        if (hit) begin
            nreq = 0;
            e.err = 1'b0;
            m_load = m_bd;
        end else if (term == T_NONE || w >= TO) begin
            nreq = TO;
            e.err = 1'b1;
            m_bv = 1'b0;
        end else begin
            nreq = w + 1;
            e.err = (term == T_ERR);
            if (e.err) m_bv = 1'b0;
            else if (!wr) begin
                m_load = rdat; m_bv = 1'b1; m_ba = wa; m_bd = rdat;
            end else if (m_bv && m_ba == wa) m_bd = sdat;
        end
        e.data = m_load;
        e.exp_cyc = cyc + 1 + nreq;
        sb.push_back(e);

        dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = sdat;
        @(posedge CLK);
        for (int j = 0; j < nreq; j++) begin
            @(negedge CLK);
            chk("ram_req_outputs", {30'd0, ramREN, ramWEN, ramaddr, ramstore}, {30'd0, !wr, wr, wa, sdat});
            if (j < w) ramstate = 2'($urandom_range(0, 1));
            else if (term == T_ACC) ramstate = RS_ACCESS;
            else if (term == T_ERR) ramstate = RS_ERROR;
            else ramstate = RS_BUSY;
            ramload = (ramstate == RS_ACCESS) ? rdat : $urandom;
            dmemaddr = $urandom;
            dmemstore = $urandom;
            @(posedge CLK);
        end
        @(negedge CLK);
        chk("ram_enables_in_done", 96'({ramREN, ramWEN}), 96'd0);
        dmemREN = 1'b0; dmemWEN = 1'b0; ramstate = RS_FREE; ramload = $urandom;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] a;
        int sel, tr;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dhit", 96'(dhit), 96'd0);
        chk("rst_derror", 96'(derror), 96'd0);
        chk("rst_dmemload", 96'(dmemload), 96'd0);
        chk("rst_ram_enables", 96'({ramREN, ramWEN}), 96'd0);
        chk("rst_ramaddr", 96'(ramaddr), 96'd0);
        chk("rst_ramstore", 96'(ramstore), 96'd0);
        nRST = 1'b1;
        @(negedge CLK);

        txn(1'b1, 1'b0, 32'h104, 32'h0, 0, T_ACC, 32'hDEADBEEF);
        txn(1'b0, 1'b1, 32'h20B, 32'h12345678, 3, T_ACC, 32'h0BADF00D);
        txn(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1, T_ACC, 32'h55555555);
        txn(1'b1, 1'b0, 32'h500, 32'h0, 0, T_NONE, 32'h11111111);
        txn(1'b1, 1'b0, 32'h600, 32'h0, 2, T_ERR, 32'h22222222);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 1, T_ACC, 32'hAA);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 0, T_ACC, 32'h77);
        txn(1'b0, 1'b1, 32'h40, 32'hBB, 0, T_ACC, 32'h0);
        txn(1'b1, 1'b0, 32'h41, 32'h0, 2, T_ACC, 32'h99);

        for (int i = 0; i < 300; i++) begin
            a = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            tr = $urandom_range(0, 9);
            txn(sel != 2, sel >= 2, a, $urandom, $urandom_range(0, 5),
                (tr < 6) ? T_ACC : ((tr < 8) ? T_ERR : T_NONE), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // reset in the middle of a load discards it without dhit
        dmemREN = 1'b1; dmemaddr = 32'h80;
        @(posedge CLK);
        @(negedge CLK);
        chk("ramREN_before_reset", 96'(ramREN), 96'd1);
        nRST = 1'b0; ramstate = RS_BUSY;
        @(posedge CLK);
        @(negedge CLK);
        dmemREN = 1'b0; ramstate = RS_FREE;
        chk("reset_midop_outputs", 96'({ramREN, ramWEN, dhit}), 96'd0);
        chk("reset_midop_dmemload", 96'(dmemload), 96'd0);
        chk("reset_midop_ramaddr", 96'(ramaddr), 96'd0);
        nRST = 1'b1;
        m_load = '0; m_bv = 1'b0;
        @(negedge CLK);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 1, T_ACC, 32'h3C3C3C3C);

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", 96'(sb.size()), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
